// File: rtl/rr_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: requester count,
// index width, FSM state encoding and a one-hot helper.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// Combinational round-robin picker: first set bit of eff_req_i scanning
// upward from ptr_i with wrap-around.
module rr_arbiter8_pick
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] eff_req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] lsh;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;

    // Rotate right by ptr so the highest-priority requester lands on bit 0;
    // the left-shift amount (8 - ptr) mod 8 falls out of 3-bit wrap-around.
    assign lsh = IDX_W'(0) - ptr_i;
    assign rot = (eff_req_i >> ptr_i) | (eff_req_i << lsh);

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDX_W'(i);
            end
        end
    end

    assign any_o = |eff_req_i;
    assign idx_o = off + ptr_i;

endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered one-hot grant, rotating
// priority pointer and an optional per-tenure hold limit.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] eff_req;
    logic             any_req;
    logic [IDX_W-1:0] pick_idx;

    assign eff_req = req_i & mask_i;

    rr_arbiter8_pick u_pick (
        .eff_req_i (eff_req),
        .ptr_i     (ptr_q),
        .any_o     (any_req),
        .idx_o     (pick_idx)
    );

    // Release has priority over the hold limit, so a requester dropping on
    // the limit edge never sees a timeout pulse.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    grant_d = onehot(pick_idx);
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!eff_req[idx_q]) begin
                    grant_d = '0;
                    ptr_d   = idx_q + IDX_W'(1);
                    state_d = ST_IDLE;
                end else if ((HOLD_MAX != 0) && (cnt_q == HOLD_LAST)) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = idx_q + IDX_W'(1);
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = |grant_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Randomised and directed bench for rr_arbiter8: a tenure-level reference model
// queues expected outputs per edge and a monitor process compares them.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_i;
    logic [7:0] mask_i;
    logic [7:0] grant_o;
    logic [2:0] grant_idx_o;
    logic       busy_o;
    logic       timeout_o;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t expQ[$];
    int   startQ[$];
    int   checks = 0;
    int   errors = 0;
    int   timeoutSeen = 0;
    logic prevBusy = 1'b0;

    // Reference model: who owns the resource, for how many cycles, and where
    // the next search starts.
    logic mBusy;
    int   mOwner;
    int   mHeld;
    int   mPtr;
    logic mTimeout;

    rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .mask_i      (mask_i),
        .grant_o     (grant_o),
        .grant_idx_o (grant_idx_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int refPick(input logic [7:0] e, input int p);
        for (int k = 0; k < 8; k++) begin
            if (e[(p + k) % 8]) return (p + k) % 8;
        end
        return 0;
    endfunction

    task automatic modelReset();
        mBusy = 1'b0; mOwner = 0; mHeld = 0; mPtr = 0; mTimeout = 1'b0;
    endtask

    task automatic modelStep(input logic [7:0] e);
        mTimeout = 1'b0;
        if (!mBusy) begin
            if (e != 8'h00) begin
                mOwner = refPick(e, mPtr);
                mBusy  = 1'b1;
                mHeld  = 1;
            end
        end else if (!e[mOwner]) begin
            mBusy = 1'b0;
            mPtr  = (mOwner + 1) % 8;
        end else if (mHeld == HOLD) begin
            mBusy    = 1'b0;
            mTimeout = 1'b1;
            mPtr     = (mOwner + 1) % 8;
        end else begin
            mHeld++;
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the DUT
    // must show after the following rising edge.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] m);
        exp_t e;
        @(negedge clk);
        req_i  = r;
        mask_i = m;
        modelStep(r & m);
        e.grant   = mBusy ? 8'(1 << mOwner) : 8'h00;
        e.idx     = 3'(mOwner);
        e.busy    = mBusy;
        e.timeout = mTimeout;
        expQ.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("grant", 32'(grant_o), 32'(e.grant));
            checkOutput("grant_idx", 32'(grant_idx_o), 32'(e.idx));
            checkOutput("busy", 32'(busy_o), 32'(e.busy));
            checkOutput("timeout", 32'(timeout_o), 32'(e.timeout));
        end
        if (busy_o && !prevBusy) startQ.push_back(int'(grant_idx_o));
        if (timeout_o) timeoutSeen++;
        prevBusy = busy_o;
    end

    initial begin
        logic [7:0] r;
        logic [7:0] m;
        int         guard;
        int         rotExp[9];

        rst_n  = 1'b0;
        req_i  = 8'hFF;
        mask_i = 8'hFF;
        modelReset();

        // Reset holds everything idle even with every request raised
        #12;
        checkOutput("rst_grant", 32'(grant_o), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_timeout", 32'(timeout_o), 32'h0);
        checkOutput("rst_idx", 32'(grant_idx_o), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Rotation: first grant right after reset, then each owner drops after 3 cycles
        startQ.delete();
        applyStimulus(8'hFF, 8'hFF);
        for (int i = 0; i < 36; i++) begin
            r = (mBusy && mHeld == 3) ? (8'hFF & ~8'(1 << mOwner)) : 8'hFF;
            applyStimulus(r, 8'hFF);
        end
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        rotExp = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
        checkOutput("rot_count", 32'(startQ.size() >= 9), 32'h1);
        for (int i = 0; i < 9; i++) begin
            checkOutput("rot_order", (i < startQ.size()) ? 32'(startQ[i]) : 32'hDEAD, 32'(rotExp[i]));
        end

        // Sparse request with wrap from pointer 6
        applyStimulus(8'h20, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        startQ.delete();
        applyStimulus(8'h22, 8'hFF);
        applyStimulus(8'h22, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h20, 8'hFF);
        applyStimulus(8'h20, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        checkOutput("wrap_first", (startQ.size() > 0) ? 32'(startQ[0]) : 32'hDEAD, 32'd1);
        checkOutput("wrap_second", (startQ.size() > 1) ? 32'(startQ[1]) : 32'hDEAD, 32'd5);

        // Hold limit: a stuck requester is cut off twice in 12 cycles
        timeoutSeen = 0;
        for (int i = 0; i < 12; i++) applyStimulus(8'h10, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        checkOutput("limit_pulses", 32'(timeoutSeen), 32'd2);

        // Masking the owner releases quietly; so does dropping on the limit edge
        timeoutSeen = 0;
        applyStimulus(8'h04, 8'hFF);
        applyStimulus(8'h04, 8'hFF);
        applyStimulus(8'h04, 8'hFB);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h04, 8'hFF);
        guard = 0;
        while (mBusy && mHeld < HOLD && guard < 10) begin
            applyStimulus(8'h04, 8'hFF);
            guard++;
        end
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        checkOutput("no_timeout", 32'(timeoutSeen), 32'd0);

        // Mid-tenure asynchronous reset, then the pointer restarts at 0
        applyStimulus(8'h40, 8'hFF);
        applyStimulus(8'h40, 8'hFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_grant", 32'(grant_o), 32'h0);
        checkOutput("async_busy", 32'(busy_o), 32'h0);
        checkOutput("async_timeout", 32'(timeout_o), 32'h0);
        modelReset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'hFF, 8'hFF);
        applyStimulus(8'h00, 8'hFF);
        applyStimulus(8'h00, 8'hFF);

        // Random sticky requests with occasional mask changes
        r = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = r ^ 8'(1 << $urandom_range(0, 7));
            m = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
            applyStimulus(r, m);
        end

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
